seg7_capture: RTL and testbench

Sequential monitor for a multiplexed, active-low 7-segment display bus: it samples the segment lines and one-hot digit selects, filters out switching glitches, decodes each stable pattern back to a 4-bit hex value, and assembles a complete multi-digit frame. It is the receiving end of the hex-to-segment encoding used throughout the lab designs. It sits on the board-facing segment/anode nets (or on a scanned display driver's outputs in loopback) and feeds recovered values to self-check logic or the host interface through a valid/ready handshake.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_stable_filter.sv | 65 ++++++
 rtl/seg7_capture.sv | 105 ++++++++++
 tb/tb_seg7_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low hex glyph table and the inverse decode.
// The display encoder uses the same table, so both directions always agree.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns for 0..F, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic       invalid;
    logic       blank;
    logic [3:0] value;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t d;
    d.invalid = 1'b1;
    d.blank   = 1'b0;
    d.value   = 4'h0;
    if (seg == SEG_BLANK) begin
      d.invalid = 1'b0;
      d.blank   = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg == SEG_HEX[i]) begin
          d.invalid = 1'b0;
          d.value   = 4'(i);
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Registers the segment/select bus and emits one capture strobe per stable dwell.
// Decisions compare the two most recent registered samples, never the raw pins.
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [6:0]            i_seg,
  input  logic [NUM_DIGITS-1:0] i_sel,
  output logic [6:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_sel,
  output logic                  o_capture
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);

  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [6:0]            r_prev_seg;
  logic [NUM_DIGITS-1:0] r_prev_sel;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;

  logic w_match;
  logic w_onehot;
  logic w_capture;

  assign w_match   = (r_seg == r_prev_seg) && (r_sel == r_prev_sel);
  assign w_onehot  = (r_sel != '0) && ((r_sel & (r_sel - NUM_DIGITS'(1))) == '0);
  // The strobe fires on the edge that carries the count to its saturation value
  assign w_capture = w_match && w_onehot && !r_done && (r_cnt == CNT_PRE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seg      <= SEG_BLANK;
      r_sel      <= '0;
      r_prev_seg <= SEG_BLANK;
      r_prev_sel <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_seg      <= i_seg;
      r_sel      <= i_sel;
      r_prev_seg <= r_seg;
      r_prev_sel <= r_sel;
      if (!w_match || !w_onehot) begin
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
        if (w_capture) r_done <= 1'b1;
      end
    end
  end

  assign o_seg     = r_seg;
  assign o_sel     = r_sel;
  assign o_capture = w_capture;

endmodule

// File: rtl/seg7_capture.sv
// Recovers hex digits from a scanned active-low 7-segment bus and assembles
// whole frames, delivered through a valid/ready handshake with overrun flag.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [6:0]              i_seg_in,
  input  logic [NUM_DIGITS-1:0]   i_digit_sel,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_blank,
  output logic [NUM_DIGITS-1:0]   o_invalid,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_overrun
);

  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_sel;
  logic                  w_capture;
  seg7_dec_t             w_dec;

  logic [4*NUM_DIGITS-1:0] r_slot_val;
  logic [NUM_DIGITS-1:0]   r_slot_blank;
  logic [NUM_DIGITS-1:0]   r_slot_inv;
  logic [NUM_DIGITS-1:0]   r_seen;

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_invalid;
  logic                    r_out_valid;
  logic                    r_overrun;

  logic                  w_full;
  logic                  w_accept;
  logic                  w_load;
  logic [NUM_DIGITS-1:0] w_seen_next;

  seg7_stable_filter #(
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_seg     (i_seg_in),
    .i_sel     (i_digit_sel),
    .o_seg     (w_seg),
    .o_sel     (w_sel),
    .o_capture (w_capture)
  );

  assign w_dec    = seg7_decode(w_seg);
  assign w_full   = &r_seen;
  assign w_accept = r_out_valid && i_out_ready;
  // A completed frame loads only if the output register is free or being drained now
  assign w_load   = w_full && (!r_out_valid || i_out_ready);

  always_comb begin
    w_seen_next = w_full ? '0 : r_seen;
    if (w_capture) w_seen_next = w_seen_next | w_sel;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slot_val   <= '0;
      r_slot_blank <= '0;
      r_slot_inv   <= '0;
      r_seen       <= '0;
      r_digits     <= '0;
      r_blank      <= '0;
      r_invalid    <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_seen <= w_seen_next;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && w_sel[i]) begin
          r_slot_val[4*i +: 4] <= w_dec.value;
          r_slot_blank[i]      <= w_dec.blank;
          r_slot_inv[i]        <= w_dec.invalid;
        end
      end
      if (w_load) begin
        r_digits    <= r_slot_val;
        r_blank     <= r_slot_blank;
        r_invalid   <= r_slot_inv;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) r_overrun <= 1'b0;
      else if (w_full && !w_load) r_overrun <= 1'b1;
    end
  end

  assign o_digits    = r_digits;
  assign o_blank     = r_blank;
  assign o_invalid   = r_invalid;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed and randomized bench for seg7_capture, every cycle compared
// against a run-length based reference model of the capture/frame rules.
module tb_seg7_capture;

  localparam int ND = 4;
  localparam int S  = 4;
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_in;
  logic [ND-1:0] sel;
  logic          rdy;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] blank, invalid;
  logic          valid, overrun;

  int checks = 0;
  int errors = 0;
  int vpulses = 0;
  logic v_prev = 1'b0;

  logic [6:0]      m_last_seg;
  logic [ND-1:0]   m_last_sel;
  int              m_run;
  logic [ND-1:0]   m_seen;
  logic [4*ND-1:0] m_slot_val;
  logic [ND-1:0]   m_slot_b, m_slot_i;
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_blank, m_invalid;
  logic            m_valid, m_overrun;

  always #5 clk = ~clk;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_seg_in    (seg_in),
    .i_digit_sel (sel),
    .o_digits    (digits),
    .o_blank     (blank),
    .o_invalid   (invalid),
    .o_out_valid (valid),
    .i_out_ready (rdy),
    .o_overrun   (overrun)
  );

  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    if (s == 7'h7F) return 6'b010000;
    for (int i = 0; i < 16; i++) if (HEX[i] == s) return {2'b00, 4'(i)};
    return 6'b100000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference: a digit is taken once its input run reaches S samples
  task automatic model_edge(input logic [6:0] s, input logic [ND-1:0] d, input logic r, input logic rd);
    logic cap, full, acc;
    logic [5:0] dec;
    if (r) begin
      m_seen = '0; m_slot_val = '0; m_slot_b = '0; m_slot_i = '0;
      m_digits = '0; m_blank = '0; m_invalid = '0; m_valid = 1'b0; m_overrun = 1'b0;
      m_last_seg = 7'h7F; m_last_sel = '0; m_run = 1;
      return;
    end
    cap  = (m_run == S) && ($countones(m_last_sel) == 1);
    full = (m_seen == '1);
    acc  = m_valid && rd;
    if (full) begin
      if (!m_valid || rd) begin
        m_digits = m_slot_val; m_blank = m_slot_b; m_invalid = m_slot_i; m_valid = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
      m_seen = '0;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (acc) m_overrun = 1'b0;
    if (cap) begin
      dec = ref_decode(m_last_seg);
      for (int i = 0; i < ND; i++) begin
        if (m_last_sel[i]) begin
          m_slot_val[4*i +: 4] = dec[3:0];
          m_slot_b[i] = dec[4];
          m_slot_i[i] = dec[5];
          m_seen[i] = 1'b1;
        end
      end
    end
    if (s == m_last_seg && d == m_last_sel) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1; m_last_seg = s; m_last_sel = d;
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [ND-1:0] d, input logic rd, input logic r);
    seg_in = s; sel = d; rdy = rd; rst = r;
    @(posedge clk);
    #1;
    model_edge(s, d, r, rd);
    chk("valid", 32'(valid), 32'(m_valid));
    chk("digits", 32'(digits), 32'(m_digits));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("invalid", 32'(invalid), 32'(m_invalid));
    chk("overrun", 32'(overrun), 32'(m_overrun));
    if (valid && !v_prev) vpulses++;
    v_prev = valid;
  endtask

  task automatic dwell(input logic [6:0] s, input logic [ND-1:0] d, input int n, input logic rd);
    for (int i = 0; i < n; i++) step(s, d, rd, 1'b0);
  endtask

  task automatic scan(input logic [27:0] pats, input int n, input logic rd);
    for (int k = 0; k < ND; k++) dwell(pats[7*k +: 7], ND'(1 << k), n, rd);
  endtask

  initial begin
    int p0;
    logic [6:0] rs;
    logic [ND-1:0] rsel;
    int n, bias;
    logic [27:0] pats;

    step(7'h7F, '0, 1'b0, 1'b1);
    step(7'h7F, '0, 1'b0, 1'b1);
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    dwell(7'h7F, '0, 3, 1'b1);

    // digits 1,2,3,4 with ready held high
    p0 = vpulses;
    scan({7'h19, 7'h30, 7'h24, 7'h79}, 8, 1'b1);
    dwell(7'h7F, '0, 4, 1'b1);
    chk("t1_pulses", 32'(vpulses - p0), 32'd1);
    chk("t1_digits", 32'(digits), 32'h4321);
    chk("t1_blank", 32'(blank), 32'h0);
    chk("t1_invalid", 32'(invalid), 32'h0);

    // two-cycle blank glitches between dwells are filtered out
    p0 = vpulses;
    pats = {7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < ND; k++) begin
      dwell(pats[7*k +: 7], ND'(1 << k), 8, 1'b1);
      if (k < ND - 1) dwell(7'h7F, ND'(1 << (k + 1)), 2, 1'b1);
    end
    dwell(7'h7F, '0, 4, 1'b1);
    chk("t2_pulses", 32'(vpulses - p0), 32'd1);
    chk("t2_digits", 32'(digits), 32'h4321);
    chk("t2_blank", 32'(blank), 32'h0);

    // blank and non-hex patterns
    scan({7'h19, 7'h7F, 7'h79, 7'h55}, 8, 1'b1);
    dwell(7'h7F, '0, 4, 1'b1);
    chk("t3_blank", 32'(blank), 32'b0100);
    chk("t3_invalid", 32'(invalid), 32'b0001);
    chk("t3_digits", 32'(digits), 32'h4010);

    // back-pressure across two full scans
    scan({7'h00, 7'h78, 7'h02, 7'h12}, 8, 1'b0);
    dwell(7'h7F, '0, 3, 1'b0);
    chk("t4_valid1", 32'(valid), 32'h1);
    chk("t4_digits1", 32'(digits), 32'h8765);
    chk("t4_ovr1", 32'(overrun), 32'h0);
    scan({7'h46, 7'h03, 7'h08, 7'h10}, 8, 1'b0);
    dwell(7'h7F, '0, 3, 1'b0);
    chk("t4_digits2", 32'(digits), 32'h8765);
    chk("t4_ovr2", 32'(overrun), 32'h1);
    step(7'h7F, '0, 1'b1, 1'b0);
    chk("t4_valid_acc", 32'(valid), 32'h0);
    chk("t4_ovr_acc", 32'(overrun), 32'h0);

    // no-select and multi-select never write a slot
    p0 = vpulses;
    dwell(7'h00, 4'b0000, 10, 1'b1);
    dwell(7'h00, 4'b0011, 10, 1'b1);
    for (int k = 1; k < ND; k++) dwell(HEX[k], ND'(1 << k), 8, 1'b1);
    dwell(7'h7F, '0, 4, 1'b1);
    chk("t5_no_frame", 32'(vpulses - p0), 32'd0);
    dwell(HEX[0], 4'b0001, 8, 1'b1);
    dwell(7'h7F, '0, 4, 1'b1);
    chk("t5_pulses", 32'(vpulses - p0), 32'd1);
    chk("t5_digits", 32'(digits), 32'h3210);

    // reset mid-frame discards the partial frame
    p0 = vpulses;
    for (int k = 0; k < 3; k++) dwell(HEX[5 + k], ND'(1 << k), 8, 1'b1);
    step(7'h7F, '0, 1'b1, 1'b1);
    scan({7'h21, 7'h46, 7'h03, 7'h08}, 8, 1'b1);
    dwell(7'h7F, '0, 4, 1'b1);
    chk("t6_pulses", 32'(vpulses - p0), 32'd1);
    chk("t6_digits", 32'(digits), 32'hDCBA);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      n = $urandom_range(0, 9);
      if (n < 8) rsel = ND'(1 << $urandom_range(0, ND - 1));
      else if (n == 8) rsel = '0;
      else rsel = ND'($urandom_range(0, 15));
      n = $urandom_range(0, 9);
      if (n < 7) rs = HEX[$urandom_range(0, 15)];
      else if (n == 7) rs = 7'h7F;
      else rs = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 9);
      bias = $urandom_range(0, 4);
      if ($urandom_range(0, 99) == 0) step(rs, rsel, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) step(rs, rsel, 1'($urandom_range(0, 3) < bias), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
